// File: rtl/rcu_define.sv
// ---------------------------------------------------------------------------
// rcu_define
//   Shared RCU definitions. Holds the state encoding of the PLL lock monitor
//   so that the RTL, status readback and any checker bound to state_o all use
//   the same numbers.
// ---------------------------------------------------------------------------
package rcu_define;

   localparam int RCU_LMON_STATE_WIDTH = 3;

   typedef enum logic [RCU_LMON_STATE_WIDTH-1:0] {
      RCU_LMON_IDLE   = 3'd0,
      RCU_LMON_WAIT   = 3'd1,
      RCU_LMON_STABLE = 3'd2,
      RCU_LMON_LOCKED = 3'd3,
      RCU_LMON_FAIL   = 3'd4
   } rcu_lmon_state_e;

endpackage

// File: rtl/dffr.sv
// ---------------------------------------------------------------------------
// dffr
//   Shared register cell: D flip-flop with asynchronous active-low reset to 0.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   d     - data in
//   q     - registered data out
// ---------------------------------------------------------------------------
module dffr #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= d;
   end

endmodule

// File: rtl/rcu_pll_lock_mon_sync.sv
// ---------------------------------------------------------------------------
// rcu_lock_sync
//   Multi-flop synchroniser for a single asynchronous level signal, built as
//   a chain of dffr cells. SYNC_STAGES must be at least 2.
// Ports:
//   clk      - destination clock
//   rst_n    - asynchronous active-low reset (chain clears to 0)
//   async_in - asynchronous input level
//   sync_out - synchronised level, SYNC_STAGES edges behind async_in
// ---------------------------------------------------------------------------
module rcu_lock_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   // stage[0] is the raw input, stage[i] is the output of flop i.
   logic [SYNC_STAGES:0] stage;

   assign stage[0] = async_in;

   for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
      dffr #(.WIDTH(1)) u_ff (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (stage[i]),
         .q     (stage[i+1])
      );
   end

   assign sync_out = stage[SYNC_STAGES];

endmodule

// File: rtl/rcu_pll_lock_mon.sv
// ---------------------------------------------------------------------------
// rcu_pll_lock_mon
//   Qualifies the raw PLL lock flag on the reference clock. Lock must hold for
//   stable_cnt_i+1 cycles before the PLL clock is selected; acquisition can
//   time out; losing lock while selected falls back to the bypass clock on
//   the next edge.
// Ports:
//   clk_i, rst_n_i - reference clock, asynchronous active-low reset
//   en_i           - monitor enable; low forces IDLE
//   pll_lock_i     - raw PLL lock, asynchronous
//   stable_cnt_i   - extra qualification cycles
//   timeout_i      - acquisition timeout in cycles, 0 = no timeout
//   clr_i          - clears the sticky flags (a same-cycle set wins)
//   pll_sel_o      - 1 selects the PLL clock (registered)
//   locked_o       - qualified lock (registered)
//   timeout_o      - sticky: acquisition timed out
//   lost_o         - sticky: lock lost while LOCKED
//   state_o        - FSM state for status readback
// ---------------------------------------------------------------------------
module rcu_pll_lock_mon
   import rcu_define::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic                            en_i,
   input  logic                            pll_lock_i,
   input  logic [CNT_WIDTH-1:0]            stable_cnt_i,
   input  logic [CNT_WIDTH-1:0]            timeout_i,
   input  logic                            clr_i,
   output logic                            pll_sel_o,
   output logic                            locked_o,
   output logic                            timeout_o,
   output logic                            lost_o,
   output logic [RCU_LMON_STATE_WIDTH-1:0] state_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   rcu_lmon_state_e      state_q, state_d;
   logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
   logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
   logic [CNT_WIDTH-1:0] tcnt_inc;
   logic                 lock_s;
   logic                 timeout_hit;
   logic                 set_timeout, set_lost;
   logic                 pll_sel_q, locked_q, timeout_q, lost_q;

   rcu_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .async_in (pll_lock_i),
      .sync_out (lock_s)
   );

   // Timeout counter saturates instead of wrapping.
   assign tcnt_inc = (tcnt_q == CNT_MAX) ? tcnt_q : tcnt_q + CNT_ONE;

   // >= so that lowering timeout_i below an already-running count still
   // fires on the next compare instead of never.
   assign timeout_hit = (timeout_i != '0) && (tcnt_q >= timeout_i);

   always_comb begin
      state_d     = state_q;
      scnt_d      = scnt_q;
      tcnt_d      = tcnt_q;
      set_timeout = 1'b0;
      set_lost    = 1'b0;
      if (!en_i) begin
         state_d = RCU_LMON_IDLE;
         scnt_d  = '0;
         tcnt_d  = '0;
      end else begin
         case (state_q)
            RCU_LMON_IDLE: begin
               state_d = RCU_LMON_WAIT;
               tcnt_d  = '0;
            end
            RCU_LMON_WAIT: begin
               tcnt_d = tcnt_inc;
               if (lock_s) begin
                  state_d = RCU_LMON_STABLE;
                  scnt_d  = '0;
               end else if (timeout_hit) begin
                  state_d     = RCU_LMON_FAIL;
                  set_timeout = 1'b1;
               end
            end
            RCU_LMON_STABLE: begin
               tcnt_d = tcnt_inc;
               if (!lock_s) begin
                  state_d = RCU_LMON_WAIT;
                  scnt_d  = '0;
               end else if (scnt_q >= stable_cnt_i) begin
                  // >= handles stable_cnt_i being lowered below scnt mid-dwell.
                  state_d = RCU_LMON_LOCKED;
               end else if (timeout_hit) begin
                  state_d     = RCU_LMON_FAIL;
                  set_timeout = 1'b1;
               end else begin
                  scnt_d = scnt_q + CNT_ONE;
               end
            end
            RCU_LMON_LOCKED: begin
               if (!lock_s) begin
                  state_d  = RCU_LMON_WAIT;
                  set_lost = 1'b1;
                  tcnt_d   = '0;
               end
            end
            RCU_LMON_FAIL: begin
               state_d = RCU_LMON_FAIL;
            end
            default: begin
               state_d = RCU_LMON_IDLE;
               scnt_d  = '0;
               tcnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= RCU_LMON_IDLE;
         scnt_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // pll_sel/locked come straight from flops (decoded from the next state) so
   // the clock-mux enable is glitch-free and still changes on the same edge
   // as the state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pll_sel_q <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
         lost_q    <= 1'b0;
      end else begin
         pll_sel_q <= (state_d == RCU_LMON_LOCKED);
         locked_q  <= (state_d == RCU_LMON_LOCKED);
         timeout_q <= set_timeout | (timeout_q & ~clr_i);
         lost_q    <= set_lost    | (lost_q    & ~clr_i);
      end
   end

   assign pll_sel_o = pll_sel_q;
   assign locked_o  = locked_q;
   assign timeout_o = timeout_q;
   assign lost_o    = lost_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_rcu_pll_lock_mon.sv
module tb_rcu_pll_lock_mon;

   localparam int CW = 16;
   localparam int SS = 2;
   localparam int TMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          pll_lock = 1'b0;
   logic          clr = 1'b0;
   logic [CW-1:0] stable_cnt = '0;
   logic [CW-1:0] timeout = '0;
   logic          pll_sel, locked, timeout_f, lost;
   logic [2:0]    state;

   int vec_cnt = 0;
   int err_cnt = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   rcu_pll_lock_mon #(.CNT_WIDTH(CW), .SYNC_STAGES(SS)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .en_i         (en),
      .pll_lock_i   (pll_lock),
      .stable_cnt_i (stable_cnt),
      .timeout_i    (timeout),
      .clr_i        (clr),
      .pll_sel_o    (pll_sel),
      .locked_o     (locked),
      .timeout_o    (timeout_f),
      .lost_o       (lost),
      .state_o      (state)
   );

   // ---------------- reference model ----------------
   // Synchroniser as a delay queue, phase numbers as plain ints, counters as
   // unbounded ints clipped to the counter range.
   int m_sync[$];
   int m_state, m_scnt, m_tcnt;
   bit m_to, m_lost;

   function automatic void m_reset();
      m_sync = {};
      for (int i = 0; i < SS; i++) m_sync.push_back(0);
      m_state = 0; m_scnt = 0; m_tcnt = 0; m_to = 0; m_lost = 0;
   endfunction

   function automatic void m_step();
      int ns, nsc, ntc, tsat;
      bit ls, hit, set_to, set_lost;
      ls   = (m_sync[SS-1] != 0);
      hit  = (timeout != 0) && (m_tcnt >= int'(timeout));
      tsat = (m_tcnt < TMAX) ? m_tcnt + 1 : TMAX;
      ns = m_state; nsc = m_scnt; ntc = m_tcnt; set_to = 0; set_lost = 0;
      if (!en) begin
         ns = 0; nsc = 0; ntc = 0;
      end else if (m_state == 0) begin
         ns = 1; ntc = 0;
      end else if (m_state == 1) begin
         ntc = tsat;
         if (ls) begin ns = 2; nsc = 0; end
         else if (hit) begin ns = 4; set_to = 1; end
      end else if (m_state == 2) begin
         ntc = tsat;
         if (!ls) begin ns = 1; nsc = 0; end
         else if (m_scnt >= int'(stable_cnt)) ns = 3;
         else if (hit) begin ns = 4; set_to = 1; end
         else nsc = m_scnt + 1;
      end else if (m_state == 3) begin
         if (!ls) begin ns = 1; set_lost = 1; ntc = 0; end
      end
      m_state = ns; m_scnt = nsc; m_tcnt = ntc;
      m_to   = set_to   || (m_to   && !clr);
      m_lost = set_lost || (m_lost && !clr);
      m_sync.push_front(int'(pll_lock));
      m_sync = m_sync[0:SS-1];
   endfunction

   function automatic logic [6:0] m_exp();
      return {m_state == 3, m_state == 3, m_to, m_lost, 3'(m_state)};
   endfunction

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      if (!rst_n) m_reset();
      else        m_step();
      #1;
   endtask

   task automatic drive_to_locked(input string tag);
      int n;
      en = 1'b1; pll_lock = 1'b1;
      n = 0;
      while (locked !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      vec_cnt++;
      if (locked !== 1'b1) begin
         err_cnt++;
         $display("FAIL %s_lock_wait: locked=%b after %0d cycles, required 1", tag, locked, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2;
      vec_cnt++;
      if ({pll_sel, locked, timeout_f, lost, state} !== 7'd0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got %b, required 0000000", {pll_sel, locked, timeout_f, lost, state});
      end
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      vec_cnt++;
      if (state !== 3'd0) begin
         err_cnt++;
         $display("FAIL reset_idle: state=%0d, required 0", state);
      end
   endtask

   // Lock rises at E, locked/pll_sel must rise at E+7 with states 1,2,3.
   task automatic test_lock_latency();
      int exp_st;
      stable_cnt = 16'd4; timeout = '0; pll_lock = 1'b0; en = 1'b1;
      tick();
      pll_lock = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         tick();
         exp_st = (k < 2) ? 1 : (k < 7) ? 2 : 3;
         vec_cnt++;
         if (state !== 3'(exp_st) || locked !== (k >= 7) || pll_sel !== (k >= 7)) begin
            err_cnt++;
            $display("FAIL latency_k%0d: state=%0d locked=%b pll_sel=%b, required state=%0d locked=%b",
                     k, state, locked, pll_sel, exp_st, k >= 7);
         end
      end
   endtask

   // One-cycle glitch after three STABLE cycles: back to WAIT, then a full
   // nine-cycle requalification; lost stays 0.
   task automatic test_glitch();
      int exp_st;
      pll_lock = 1'b0; en = 1'b0;
      tick();
      stable_cnt = 16'd8; en = 1'b1;
      tick();
      for (int k = 0; k <= 17; k++) begin
         pll_lock = (k != 3);
         tick();
         exp_st = (k < 2) ? 1 : (k < 5) ? 2 : (k == 5) ? 1 : (k < 15) ? 2 : 3;
         vec_cnt++;
         if (state !== 3'(exp_st) || locked !== (k >= 15) || lost !== 1'b0) begin
            err_cnt++;
            $display("FAIL glitch_k%0d: state=%0d locked=%b lost=%b, required state=%0d locked=%b lost=0",
                     k, state, locked, lost, exp_st, k >= 15);
         end
      end
   endtask

   task automatic test_timeout();
      int exp_st;
      pll_lock = 1'b0; en = 1'b0;
      tick();
      timeout = 16'd20; en = 1'b1;
      tick();
      for (int k = 1; k <= 22; k++) begin
         tick();
         exp_st = (k < 21) ? 1 : 4;
         if (k >= 19) begin
            vec_cnt++;
            if (state !== 3'(exp_st) || timeout_f !== (k >= 21)) begin
               err_cnt++;
               $display("FAIL timeout_k%0d: state=%0d timeout=%b, required state=%0d timeout=%b",
                        k, state, timeout_f, exp_st, k >= 21);
            end
         end
      end
      en = 1'b0;
      tick();
      vec_cnt++;
      if (state !== 3'd0 || timeout_f !== 1'b1) begin
         err_cnt++;
         $display("FAIL timeout_en_off: state=%0d timeout=%b, required state=0 timeout=1", state, timeout_f);
      end
      en = 1'b1;
      tick();
      vec_cnt++;
      if (state !== 3'd1 || timeout_f !== 1'b1) begin
         err_cnt++;
         $display("FAIL timeout_en_on: state=%0d timeout=%b, required state=1 timeout=1", state, timeout_f);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      vec_cnt++;
      if (timeout_f !== 1'b0) begin
         err_cnt++;
         $display("FAIL timeout_clr: timeout=%b, required 0", timeout_f);
      end
      timeout = '0;
   endtask

   task automatic test_loss();
      en = 1'b0;
      tick();
      stable_cnt = 16'd2;
      drive_to_locked("loss");
      pll_lock = 1'b0;
      for (int k = 0; k <= 2; k++) begin
         tick();
         vec_cnt++;
         if (pll_sel !== (k < 2)) begin
            err_cnt++;
            $display("FAIL loss_sel_k%0d: pll_sel=%b, required %b", k, pll_sel, k < 2);
         end
      end
      vec_cnt++;
      if (lost !== 1'b1 || state !== 3'd1) begin
         err_cnt++;
         $display("FAIL loss_status: lost=%b state=%0d, required lost=1 state=1", lost, state);
      end
      drive_to_locked("relock");
      vec_cnt++;
      if (pll_sel !== 1'b1 || lost !== 1'b1) begin
         err_cnt++;
         $display("FAIL relock: pll_sel=%b lost=%b, required pll_sel=1 lost=1", pll_sel, lost);
      end
   endtask

   task automatic test_clr_collision();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      vec_cnt++;
      if (lost !== 1'b0) begin
         err_cnt++;
         $display("FAIL clr_lost: lost=%b, required 0", lost);
      end
      pll_lock = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      tick();
      vec_cnt++;
      if (lost !== 1'b1) begin
         err_cnt++;
         $display("FAIL clr_set_wins: lost=%b, required 1", lost);
      end
      tick();
      clr = 1'b0;
      vec_cnt++;
      if (lost !== 1'b0) begin
         err_cnt++;
         $display("FAIL clr_after_set: lost=%b, required 0", lost);
      end
   endtask

   task automatic test_async_reset();
      drive_to_locked("pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      vec_cnt++;
      if ({pll_sel, locked, timeout_f, lost, state} !== 7'd0) begin
         err_cnt++;
         $display("FAIL async_reset: got %b, required 0000000", {pll_sel, locked, timeout_f, lost, state});
      end
      tick();
      tick();
      rst_n = 1'b1;
      en = 1'b0;
      tick();
      vec_cnt++;
      if (state !== 3'd0) begin
         err_cnt++;
         $display("FAIL post_reset_idle: state=%0d, required 0", state);
      end
      drive_to_locked("post_reset");
   endtask

   task automatic test_random();
      logic [6:0] got, exp;
      for (int i = 0; i < 3000; i++) begin
         en  = ($urandom_range(0, 99) < 97);
         clr = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 9) == 0) pll_lock = ~pll_lock;
         if ($urandom_range(0, 59) == 0) begin
            stable_cnt = CW'($urandom_range(0, 6));
            timeout    = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(3, 25));
         end
         tick();
         got = {pll_sel, locked, timeout_f, lost, state};
         exp = m_exp();
         vec_cnt++;
         if (got !== exp) begin
            err_cnt++;
            $display("FAIL random_c%0d: {sel,lck,to,lost,st}=%b, required %b", i, got, exp);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      m_reset();
      test_reset();
      test_lock_latency();
      test_glitch();
      test_timeout();
      test_loss();
      test_clr_collision();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
